// File: rtl/uart_rx_oversampled_if.sv
// Receive-side character handshake: the receiver drives a character plus its
// error flags, and the consumer accepts it with ready.
interface uart_rx_oversampled_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data, valid, parity_err, frame_err, overrun,
    input  ready
  );

  modport slave (
    input  data, valid, parity_err, frame_err, overrun,
    output ready
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: synchronises rx, votes 3 mid-bit samples per bit and
// delivers each character with parity/framing flags on a valid/ready handshake.
module uart_rx_oversampled #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SAMPLE_RATE = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  rx,
  uart_rx_oversampled_if.master bus
);

  localparam int CW = $clog2(SAMPLE_RATE);
  localparam int IW = $clog2(DATA_BITS);
  localparam int M  = SAMPLE_RATE / 2;
  localparam logic [CW-1:0] C_LAST = CW'(SAMPLE_RATE - 1);
  localparam logic [CW-1:0] C_S0   = CW'(M - 1);
  localparam logic [CW-1:0] C_S1   = CW'(M);
  localparam logic [CW-1:0] C_S2   = CW'(M + 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
  localparam logic          S_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_s;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic                   s0_q, s0_d, s1_q, s1_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_bit_q, par_bit_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   zero_q, zero_d;
  logic                   armed_q, armed_d;

  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_out_q, perr_out_d;
  logic                   ferr_out_q, ferr_out_d;
  logic                   overrun_q, overrun_d;

  logic                   maj;
  logic                   wrap;
  logic                   at_mid;
  logic                   complete;
  logic                   ferr_fin;

  always_comb begin
    sync_d = sync_q;
    sync_d[0] = rx;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign maj    = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign wrap   = (cnt_q == C_LAST);
  assign at_mid = (cnt_q == C_S2);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    shreg_d    = shreg_q;
    par_bit_d  = par_bit_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    zero_d     = zero_q;
    armed_d    = armed_q;
    complete   = 1'b0;
    ferr_fin   = ferr_q;

    if (tick) begin
      if (state_q != S_IDLE) begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        if (cnt_q == C_S0) s0_d = rx_s;
        if (cnt_q == C_S1) s1_d = rx_s;
      end

      case (state_q)
        S_IDLE: begin
          // After a break the line must go high again before a new start counts.
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = S_START;
            cnt_d   = CW'(1);
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            zero_d  = 1'b1;
          end
        end

        S_START: begin
          if (at_mid && maj) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (wrap) begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end

        S_DATA: begin
          if (at_mid) begin
            shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
            if (maj) zero_d = 1'b0;
          end
          if (wrap) begin
            if (idx_q == I_LAST) begin
              state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
              stop_idx_d = 1'b0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end

        S_PARITY: begin
          if (at_mid) begin
            par_bit_d = maj;
            if (maj) zero_d = 1'b0;
          end
          if (wrap) begin
            perr_d  = (^shreg_q) ^ par_bit_q ^ (PARITY == 1);
            state_d = S_STOP;
          end
        end

        S_STOP: begin
          if (at_mid) begin
            if (!maj) ferr_d = 1'b1;
            else      zero_d = 1'b0;
            ferr_fin = ferr_q | ~maj;
            // Finish mid-bit so a start edge in the tail of the stop bit is caught.
            if (stop_idx_q == S_LAST) begin
              complete = 1'b1;
              state_d  = S_IDLE;
              cnt_d    = '0;
              armed_d  = ~(zero_q & ~maj);
            end
          end else if (wrap) begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    overrun_d  = 1'b0;

    if (complete) begin
      if (!valid_q || bus.ready) begin
        data_d     = shreg_q;
        perr_out_d = perr_q;
        ferr_out_d = ferr_fin;
        valid_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q     <= '1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      shreg_q    <= '0;
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b0;
      armed_q    <= 1'b1;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      shreg_q    <= shreg_d;
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      zero_q     <= zero_d;
      armed_q    <= armed_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.data       = data_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = perr_out_q;
  assign bus.frame_err  = ferr_out_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: an 8N1 receiver (dut0) and an 8E2 receiver at
// 8 ticks/bit (dut1), driven with table vectors, corner sequences and random frames.
module tb_uart_rx_oversampled;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tick  = 1'b1;
  logic rx0   = 1'b1;
  logic rx1   = 1'b1;

  uart_rx_oversampled_if #(.DATA_BITS(8)) if0 ();
  uart_rx_oversampled_if #(.DATA_BITS(8)) if1 ();

  uart_rx_oversampled dut0 (
    .clock (clock),
    .reset (reset),
    .tick  (tick),
    .rx    (rx0),
    .bus   (if0.master)
  );

  uart_rx_oversampled #(
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .SAMPLE_RATE(8), .SYNC_STAGES(3)
  ) dut1 (
    .clock (clock),
    .reset (reset),
    .tick  (tick),
    .rx    (rx1),
    .bus   (if1.master)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rx_t;

  typedef struct {
    int         which;
    logic [7:0] d;
    logic       par;
    logic       stop_low;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  rx_t  q0[$];
  rx_t  q1[$];
  vec_t vecs[9];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ovr0     = 0;
  int   vcyc0    = 0;
  int   vcyc1    = 0;
  int   phase    = 0;
  int   tick_div = 1;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // One clock: record accepted characters, advance, then observe outputs.
  task automatic step();
    rx_t r;
    if (if0.valid && if0.ready) begin
      r.d = if0.data; r.pe = if0.parity_err; r.fe = if0.frame_err;
      q0.push_back(r);
    end
    if (if1.valid && if1.ready) begin
      r.d = if1.data; r.pe = if1.parity_err; r.fe = if1.frame_err;
      q1.push_back(r);
    end
    @(posedge clock);
    #1;
    if (if0.overrun) ovr0++;
    if (if0.valid)   vcyc0++;
    if (if1.valid)   vcyc1++;
    phase++;
    tick = ((phase % tick_div) == 0);
  endtask

  task automatic send_bit(input int which, input logic v, input int gstart, input int glen);
    int   sr;
    logic lv;
    logic t;
    sr = (which == 0) ? 16 : 8;
    for (int i = 0; i < sr; i++) begin
      lv = (i >= gstart && i < gstart + glen) ? ~v : v;
      if (which == 0) rx0 = lv;
      else            rx1 = lv;
      do begin
        t = tick;
        step();
      end while (!t);
    end
  endtask

  task automatic idle(input int which, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(which, 1'b1, 0, 0);
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic par,
                            input logic stop_low, input int gbit, input int gstart,
                            input int glen);
    send_bit(which, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++)
      send_bit(which, d[i], (i == gbit) ? gstart : 0, (i == gbit) ? glen : 0);
    if (which == 1) send_bit(1, par, 0, 0);
    for (int s = 0; s < ((which == 1) ? 2 : 1); s++) send_bit(which, ~stop_low, 0, 0);
  endtask

  task automatic expect_char(input string name, input int which, input logic [7:0] d,
                             input logic pe, input logic fe);
    rx_t r;
    int  n;
    n = (which == 1) ? q1.size() : q0.size();
    chk($sformatf("%s.count", name), n, 1);
    if (n > 0) begin
      if (which == 1) begin r = q1.pop_front(); q1.delete(); end
      else            begin r = q0.pop_front(); q0.delete(); end
      chk($sformatf("%s.data", name), int'(r.d), int'(d));
      chk($sformatf("%s.parity_err", name), int'(r.pe), int'(pe));
      chk($sformatf("%s.frame_err", name), int'(r.fe), int'(fe));
    end
  endtask

  initial begin
    rx_t        r;
    int         which;
    logic [7:0] d;
    logic       par;
    logic       sl;
    logic       epe;

    //            which  data   par   stop_low  exp_d  exp_pe exp_fe
    vecs[0] = '{0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0};
    vecs[1] = '{1, 8'hA3, 1'b0, 1'b0, 8'hA3, 1'b0, 1'b0};
    vecs[2] = '{1, 8'hA3, 1'b1, 1'b0, 8'hA3, 1'b1, 1'b0};
    vecs[3] = '{0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
    vecs[4] = '{1, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1};
    vecs[5] = '{0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{1, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{1, 8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[8] = '{0, 8'h80, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0};

    if0.ready = 1'b1;
    if1.ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("reset.valid", int'(if0.valid), 0);
    chk("reset.data", int'(if0.data), 0);
    chk("reset.overrun", int'(if0.overrun), 0);
    idle(0, 2);
    idle(1, 2);

    for (int i = 0; i < 9; i++) begin
      vcyc0 = 0;
      vcyc1 = 0;
      send_frame(vecs[i].which, vecs[i].d, vecs[i].par, vecs[i].stop_low, -1, 0, 0);
      idle(vecs[i].which, 2);
      expect_char($sformatf("vec%0d", i), vecs[i].which, vecs[i].exp_d,
                  vecs[i].exp_pe, vecs[i].exp_fe);
      chk($sformatf("vec%0d.valid_cycles", i), (vecs[i].which == 1) ? vcyc1 : vcyc0, 1);
    end

    // Bad stop bit running straight into a long break.
    send_frame(0, 8'h3C, 1'b0, 1'b1, -1, 0, 0);
    for (int i = 0; i < 12; i++) send_bit(0, 1'b0, 0, 0);
    chk("break.count_low", q0.size(), 2);
    idle(0, 2);
    chk("break.count_high", q0.size(), 2);
    if (q0.size() == 2) begin
      r = q0.pop_front();
      chk("break.c1.data", int'(r.d), 8'h3C);
      chk("break.c1.frame_err", int'(r.fe), 1);
      r = q0.pop_front();
      chk("break.c2.data", int'(r.d), 8'h00);
      chk("break.c2.frame_err", int'(r.fe), 1);
    end
    q0.delete();
    send_frame(0, 8'h81, 1'b0, 1'b0, -1, 0, 0);
    idle(0, 2);
    expect_char("after_break", 0, 8'h81, 1'b0, 1'b0);

    // Short low glitch on an idle line, then a single-sample glitch inside a data bit.
    send_bit(0, 1'b1, 0, 4);
    idle(0, 2);
    chk("glitch.no_char", q0.size(), 0);
    send_frame(0, 8'hC5, 1'b0, 1'b0, 2, 7, 1);
    idle(0, 2);
    expect_char("glitch_bit", 0, 8'hC5, 1'b0, 1'b0);

    // Overrun: consumer stalled across two back-to-back characters.
    if0.ready = 1'b0;
    ovr0 = 0;
    send_frame(0, 8'h11, 1'b0, 1'b0, -1, 0, 0);
    send_frame(0, 8'h22, 1'b0, 1'b0, -1, 0, 0);
    idle(0, 1);
    chk("ovr.valid_held", int'(if0.valid), 1);
    chk("ovr.data_held", int'(if0.data), 8'h11);
    chk("ovr.pulses", ovr0, 1);
    chk("ovr.none_taken", q0.size(), 0);
    if0.ready = 1'b1;
    step();
    step();
    chk("ovr.valid_cleared", int'(if0.valid), 0);
    expect_char("ovr.accepted", 0, 8'h11, 1'b0, 1'b0);

    // Reset in the middle of data bit 3, then a clean character.
    send_bit(0, 1'b0, 0, 0);
    send_bit(0, 1'b0, 0, 0);
    send_bit(0, 1'b1, 0, 0);
    send_bit(0, 1'b1, 0, 0);
    rx0 = 1'b1;
    repeat (8) step();
    reset = 1'b1;
    step();
    step();
    chk("rst_mid.data", int'(if0.data), 0);
    chk("rst_mid.valid", int'(if0.valid), 0);
    chk("rst_mid.flags", int'({if0.parity_err, if0.frame_err, if0.overrun}), 0);
    reset = 1'b0;
    idle(0, 3);
    chk("rst_mid.no_char", q0.size() + int'(if0.valid), 0);
    send_frame(0, 8'h7E, 1'b0, 1'b0, -1, 0, 0);
    idle(0, 2);
    expect_char("rst_mid.7e", 0, 8'h7E, 1'b0, 1'b0);

    // Random frames against the parity/framing rules.
    for (int k = 0; k < 24; k++) begin
      which    = $urandom_range(0, 1);
      d        = 8'($urandom);
      par      = 1'($urandom_range(0, 1));
      sl       = ($urandom_range(0, 3) == 0);
      tick_div = $urandom_range(1, 3);
      epe      = (which == 1) ? 1'(($countones(d) + int'(par)) % 2) : 1'b0;
      send_frame(which, d, par, sl, -1, 0, 0);
      idle(which, $urandom_range(1, 3));
      expect_char($sformatf("rand%0d", k), which, d, epe, sl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
